// File: rtl/request_unit_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : request_unit_mc_if
// Brief    : Datapath <-> memory request bundle for request_unit_mc.
// Revision : 1.0
// ============================================================================
interface request_unit_mc_if #(
  parameter int NCH = 2
);
  logic           halt;
  logic [NCH-1:0] dREN;
  logic [NCH-1:0] dWEN;
  logic [NCH-1:0] dhit;
  logic [NCH-1:0] dmemREN;
  logic [NCH-1:0] dmemWEN;
  logic [NCH-1:0] pend;
  logic           stall;
  logic           imemREN;
  logic [NCH-1:0] err;

  // master drives requests/hits, slave is the request unit itself
  modport master (
    output halt, dREN, dWEN, dhit,
    input  dmemREN, dmemWEN, pend, stall, imemREN, err
  );

  modport slave (
    input  halt, dREN, dWEN, dhit,
    output dmemREN, dmemWEN, pend, stall, imemREN, err
  );
endinterface
`default_nettype wire

// File: rtl/request_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : request_unit_mc
// Brief    : Multi-channel memory request unit with stall and sticky fetch
//            disable. Define REQ_TIMEOUT_EN to enable the per-channel watchdog.
// Revision : 1.0
// ============================================================================
module request_unit_mc #(
  parameter int NCH     = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  request_unit_mc_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  if ((NCH < 1) || (NCH > 8) || (TIMEOUT < 1) || (TIMEOUT > (2**CNT_W) - 1)) begin : g_param_check
    $error("request_unit_mc: parameter out of range");
  end

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]   ren_q, ren_d;
  logic [NCH-1:0]   wen_q, wen_d;
  logic             imem_q, imem_d;
  logic [NCH-1:0]   pend_w;
  logic             stall_w;

`ifdef REQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  logic [NCH-1:0] err_q, err_d;
`endif

  always_comb begin
    ren_d   = ren_q;
    wen_d   = wen_q;
    pend_w  = '0;
    stall_w = 1'b0;
    imem_d  = imem_q & ~bus.halt;
`ifdef REQ_TIMEOUT_EN
    err_d   = err_q;
`endif
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      pend_w[ch]  = (state_q[ch] == PEND);
      case (state_q[ch])
        IDLE: begin
          if ((bus.dREN[ch] | bus.dWEN[ch]) && !bus.dhit[ch]) begin
            state_d[ch] = PEND;
            cnt_d[ch]   = '0;
            wen_d[ch]   = bus.dWEN[ch];
            ren_d[ch]   = bus.dREN[ch] & ~bus.dWEN[ch];
          end
        end
        PEND: begin
          // request lines are frozen here; only a hit (or watchdog) releases them
          if (bus.dhit[ch]) begin
            state_d[ch] = IDLE;
            ren_d[ch]   = 1'b0;
            wen_d[ch]   = 1'b0;
          end
`ifdef REQ_TIMEOUT_EN
          else if (cnt_q[ch] == C_TIMEOUT) begin
            state_d[ch] = IDLE;
            ren_d[ch]   = 1'b0;
            wen_d[ch]   = 1'b0;
            err_d[ch]   = 1'b1;
          end
`endif
          else if (cnt_q[ch] != C_CNT_MAX) begin
            cnt_d[ch] = cnt_q[ch] + 1'b1;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
      stall_w = stall_w
              | (pend_w[ch] & ~bus.dhit[ch])
              | ((bus.dREN[ch] | bus.dWEN[ch]) & ~pend_w[ch] & ~bus.dhit[ch]);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
      end
      ren_q  <= '0;
      wen_q  <= '0;
      imem_q <= 1'b1;
`ifdef REQ_TIMEOUT_EN
      err_q  <= '0;
`endif
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      ren_q  <= ren_d;
      wen_q  <= wen_d;
      imem_q <= imem_d;
`ifdef REQ_TIMEOUT_EN
      err_q  <= err_d;
`endif
    end
  end

  assign bus.dmemREN = ren_q;
  assign bus.dmemWEN = wen_q;
  assign bus.pend    = pend_w;
  assign bus.stall   = stall_w;
  assign bus.imemREN = imem_q;
`ifdef REQ_TIMEOUT_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_request_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_request_unit_mc
// Brief    : Directed vector bench for request_unit_mc (NCH=2, TIMEOUT=4).
// Revision : 1.0
// ============================================================================
module tb_request_unit_mc;

  localparam int C_NCH = 2;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  request_unit_mc_if #(.NCH(C_NCH)) bus ();

  request_unit_mc #(
    .NCH     (C_NCH),
    .CNT_W   (8),
    .TIMEOUT (4)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ren;
    logic [1:0] wen;
    logic [1:0] hit;
    logic       halt;
    logic [1:0] e_dmr;
    logic [1:0] e_dmw;
    logic [1:0] e_pend;
    logic       e_stall;
    logic       e_imem;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] ren, input logic [1:0] wen,
                       input logic [1:0] hit, input logic halt);
    bus.dREN = ren;
    bus.dWEN = wen;
    bus.dhit = hit;
    bus.halt = halt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    nrst  = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 1'b0);

    //               ren    wen    hit   halt  dmr    dmw    pend  stall imem
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 2'b01, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1});
    // channel 1 read+write: write wins, then inputs change while pending
    tbl.push_back('{2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1});
    tbl.push_back('{2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1});
    // write answered in the request cycle: never issued
    tbl.push_back('{2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1});
    // both channels pending, simultaneous hits
    tbl.push_back('{2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b10, 2'b11, 1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b11, 1'b0, 2'b01, 2'b10, 2'b11, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1});
    // halt pulse while channel 0 pending
    tbl.push_back('{2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 2'b01, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});

    // reset values, sampled while reset is still asserted
    #12;
    chk("rst_dmr",  {6'd0, bus.dmemREN}, 8'h00);
    chk("rst_dmw",  {6'd0, bus.dmemWEN}, 8'h00);
    chk("rst_pend", {6'd0, bus.pend},    8'h00);
    chk("rst_imem", {7'd0, bus.imemREN}, 8'h01);
    chk("rst_err",  {6'd0, bus.err},     8'h00);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].ren, tbl[i].wen, tbl[i].hit, tbl[i].halt);
      #1;
      chk($sformatf("v%0d_dmr", i),   {6'd0, bus.dmemREN}, {6'd0, tbl[i].e_dmr});
      chk($sformatf("v%0d_dmw", i),   {6'd0, bus.dmemWEN}, {6'd0, tbl[i].e_dmw});
      chk($sformatf("v%0d_pend", i),  {6'd0, bus.pend},    {6'd0, tbl[i].e_pend});
      chk($sformatf("v%0d_stall", i), {7'd0, bus.stall},   {7'd0, tbl[i].e_stall});
      chk($sformatf("v%0d_imem", i),  {7'd0, bus.imemREN}, {7'd0, tbl[i].e_imem});
      chk($sformatf("v%0d_err", i),   {6'd0, bus.err},     8'h00);
    end

    // asynchronous reset in the middle of a pending request
    @(negedge clk);
    drive(2'b00, 2'b01, 2'b00, 1'b0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    #1;
    chk("arst_pre_pend", {6'd0, bus.pend}, 8'h01);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_dmw",  {6'd0, bus.dmemWEN}, 8'h00);
    chk("arst_pend", {6'd0, bus.pend},    8'h00);
    chk("arst_imem", {7'd0, bus.imemREN}, 8'h01);
    chk("arst_stall",{7'd0, bus.stall},   8'h00);
    @(negedge clk);
    nrst = 1'b1;

    // watchdog: no hit, request issued at edge 1, counter reaches 4 after edge 5
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("to_pre_dmr", {6'd0, bus.dmemREN}, 8'h01);
    chk("to_pre_err", {6'd0, bus.err},     8'h00);
    @(negedge clk);
    #1;
`ifdef REQ_TIMEOUT_EN
    chk("to_dmr",  {6'd0, bus.dmemREN}, 8'h00);
    chk("to_pend", {6'd0, bus.pend},    8'h00);
    chk("to_err",  {6'd0, bus.err},     8'h01);
    repeat (3) @(negedge clk);
    #1;
    chk("to_err_sticky", {6'd0, bus.err}, 8'h01);
`else
    chk("to_dmr",  {6'd0, bus.dmemREN}, 8'h01);
    chk("to_pend", {6'd0, bus.pend},    8'h01);
    chk("to_err",  {6'd0, bus.err},     8'h00);
    drive(2'b00, 2'b00, 2'b01, 1'b0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    #1;
    chk("to_drain_pend", {6'd0, bus.pend}, 8'h00);
`endif

    // hit arrives in the cycle the counter reaches 4: hit wins
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    drive(2'b00, 2'b00, 2'b01, 1'b0);
    #1;
    chk("tohit_stall", {7'd0, bus.stall}, 8'h00);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    #1;
    chk("tohit_pend", {6'd0, bus.pend},    8'h00);
    chk("tohit_dmr",  {6'd0, bus.dmemREN}, 8'h00);
    chk("tohit_err",  {6'd0, bus.err},     8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
